alu_seq_handshake: RTL

//  Parametrised, registered execute-stage ALU with valid/ready handshakes on input and output.

---
 rtl/alu_seq_handshake_if.sv | 28 ++
 rtl/alu_seq_handshake.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_handshake_if.sv
// Request/response bundle for alu_seq_handshake: op request with valid/ready,
// registered result with valid/ready. The slave side is the ALU.
interface alu_seq_handshake_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] src1_value;
  logic [XLEN-1:0] src2_value;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal_op;

  modport slave (
    input  in_valid, op, src1_value, src2_value, imm, use_imm, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );

  modport master (
    output in_valid, op, src1_value, src2_value, imm, use_imm, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_seq_handshake.sv
// Registered execute-stage ALU with valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative multiplier (op 10); otherwise op 10 is illegal.
module alu_seq_handshake #(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_seq_handshake_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  if ((XLEN < 8) || ((XLEN & (XLEN - 1)) != 0) || ((XLEN % MUL_BITS_PER_CYCLE) != 0)) begin : g_bad_param
    $error("alu_seq_handshake: XLEN must be a power of 2 >= 8 and divisible by MUL_BITS_PER_CYCLE");
  end

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
  localparam int MUL_CYC = XLEN / MUL_BITS_PER_CYCLE;
  localparam int CW      = $clog2(MUL_CYC + 1);
  logic [XLEN-1:0] mul_a_q, mul_b_q, acc_q, mul_sum_d;
  logic [CW-1:0]   cnt_q;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`endif

  state_e          state_q;
  logic [XLEN-1:0] result_q, alu_res_d, a_s, b_s;
  logic            zero_q, illegal_q, out_valid_q, alu_ill_d, in_ready_s, accept_s;
  logic [SHW-1:0]  shamt_s;

  assign a_s     = bus.src1_value;
  assign b_s     = bus.use_imm ? bus.imm : bus.src2_value;
  assign shamt_s = b_s[SHW-1:0];

  // Ready is combinational so a held result and a new request can swap on the same edge.
  always_comb begin
    in_ready_s = 1'b0;
    if (!rst_n || flush) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  in_ready_s = 1'b1;
        S_DONE:  in_ready_s = bus.out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  // Single-cycle result; anything not decoded here is flagged illegal with a zero result.
  always_comb begin
    alu_res_d = '0;
    alu_ill_d = 1'b0;
    case (bus.op)
      4'd0:    alu_res_d = a_s + b_s;
      4'd1:    alu_res_d = a_s - b_s;
      4'd2:    alu_res_d = a_s << shamt_s;
      4'd3:    alu_res_d = {{(XLEN-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
      4'd4:    alu_res_d = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      4'd5:    alu_res_d = a_s ^ b_s;
      4'd6:    alu_res_d = a_s >> shamt_s;
      4'd7:    alu_res_d = $signed(a_s) >>> shamt_s;
      4'd8:    alu_res_d = a_s | b_s;
      4'd9:    alu_res_d = a_s & b_s;
`ifdef ALU_MUL_EN
      4'd10:   alu_res_d = '0;
`endif
      default: alu_ill_d = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // Partial-product accumulation for the current slice of B.
  always_comb begin
    mul_sum_d = acc_q;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
      if (mul_b_q[k]) begin
        mul_sum_d = mul_sum_d + (mul_a_q << k);
      end else begin
        mul_sum_d = mul_sum_d;
      end
    end
  end
`endif

  // Control FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
`ifdef ALU_MUL_EN
            if (bus.op == 4'd10) begin
              mul_a_q     <= a_s;
              mul_b_q     <= b_s;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= S_MUL;
            end else
`endif
            begin
              result_q    <= alu_res_d;
              zero_q      <= (alu_res_d == '0);
              illegal_q   <= alu_ill_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc_q   <= mul_sum_d;
          mul_a_q <= mul_a_q << MUL_BITS_PER_CYCLE;
          mul_b_q <= mul_b_q >> MUL_BITS_PER_CYCLE;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_CYC - 1)) begin
            result_q    <= mul_sum_d;
            zero_q      <= (mul_sum_d == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = illegal_q;
endmodule
